neuron_slot_sched: RTL and testbench

- Time-multiplexed update scheduler for the neuron array. It replaces derived clocks with single-cycle enables on rawclk.
- A programmable divider produces a tick. Each tick issues one pipeline slot, which is a (neuron index, phase) pair, with 4 phases per neuron.
- Slots are grouped into sample frames of programmable length. Per-frame strobes and probe-tap strobes drive the datapath and the logging path.

---
 rtl/neuron_slot_sched.sv | 103 ++++++++++
 tb/tb_neuron_slot_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_slot_sched.sv
// neuron_slot_sched: divider-tick driven (neuron, phase) slot issuer with frame, probe and overrun strobes
// Ports: rawclk/reset (sync, active-high); enable run request; half_cnt divider reload (live);
// frame_len ticks per frame (latched at frame start); tap0..2/tap_en probe selects; clr_overrun.
// Outputs, all registered: tick, slot_valid, neuron_index, phase, frame_start, frame_done, tap_hit, busy, overrun.
module neuron_slot_sched #(
  parameter int NN = 8,
  parameter int CW = 32
) (
  input  logic          rawclk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] half_cnt,
  input  logic [CW-1:0] frame_len,
  input  logic [NN:0]   tap0,
  input  logic [NN:0]   tap1,
  input  logic [NN:0]   tap2,
  input  logic [2:0]    tap_en,
  input  logic          clr_overrun,
  output logic          tick,
  output logic          slot_valid,
  output logic [NN:0]   neuron_index,
  output logic [1:0]    phase,
  output logic          frame_start,
  output logic          frame_done,
  output logic [2:0]    tap_hit,
  output logic          busy,
  output logic          overrun
);
  localparam int SW = NN + 3;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] NUM_SLOTS = ONE << SW;
  localparam logic [SW-1:0] LAST = '1;
  typedef enum logic [1:0] {IDLE, SWEEP, GAP, BOUND} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d, frm_cnt_q, frm_cnt_d, frame_len_lat_q, frame_len_lat_d;
  logic [CW-1:0] frame_len_eff, frm_next;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d, out_slot_q, out_slot_d, issue;
  logic run, tick_int, start, issue_v, boundary;
  logic tick_q, valid_q, fs_q, fs_d, fd_q, fd_d, ov_q, ov_d;
  logic [2:0] hit_q, hit_d;
  always_comb begin
    run = (state_q != IDLE) || enable;
    tick_int = run && (div_cnt_q >= half_cnt);
    div_cnt_d = (!run || tick_int) ? '0 : div_cnt_q + 1'b1;
    // IDLE and BOUND both mean "the next tick opens a frame"
    start = tick_int && (state_q == IDLE || state_q == BOUND);
    frame_len_lat_d = start ? frame_len : frame_len_lat_q;
    frame_len_eff = (frame_len_lat_d < NUM_SLOTS) ? NUM_SLOTS : frame_len_lat_d;
    issue_v = tick_int && (start || state_q == SWEEP);
    issue = start ? '0 : slot_cnt_q;
    frm_next = start ? ONE : frm_cnt_q + 1'b1;
    frm_cnt_d = tick_int ? frm_next : frm_cnt_q;
    slot_cnt_d = issue_v ? issue + 1'b1 : slot_cnt_q;
    out_slot_d = issue_v ? issue : out_slot_q;
    fs_d = start;
    fd_d = issue_v && (issue == LAST);
    // with frame_len_eff == NUM_SLOTS the last slot is also the boundary, so GAP is skipped
    boundary = tick_int && (frm_next == frame_len_eff);
    state_d = boundary ? (enable ? BOUND : IDLE) : start ? SWEEP : fd_d ? GAP : state_q;
    hit_d = {issue_v && tap_en[2] && issue[1:0] == 2'd0 && issue[SW-1:2] == tap2,
             issue_v && tap_en[1] && issue[1:0] == 2'd0 && issue[SW-1:2] == tap1,
             issue_v && tap_en[0] && issue[1:0] == 2'd0 && issue[SW-1:2] == tap0};
    ov_d = (start && frame_len < NUM_SLOTS) || (ov_q && !clr_overrun);
  end
  always_ff @(posedge rawclk) begin
    if (reset) begin
      state_q <= IDLE;
      div_cnt_q <= '0;
      frm_cnt_q <= '0;
      frame_len_lat_q <= '0;
      slot_cnt_q <= '0;
      out_slot_q <= '0;
      tick_q <= 1'b0;
      valid_q <= 1'b0;
      fs_q <= 1'b0;
      fd_q <= 1'b0;
      hit_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_cnt_q <= div_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      frame_len_lat_q <= frame_len_lat_d;
      slot_cnt_q <= slot_cnt_d;
      out_slot_q <= out_slot_d;
      tick_q <= tick_int;
      valid_q <= issue_v;
      fs_q <= fs_d;
      fd_q <= fd_d;
      hit_q <= hit_d;
      ov_q <= ov_d;
    end
  end
  assign tick = tick_q;
  assign slot_valid = valid_q;
  assign neuron_index = out_slot_q[SW-1:2];
  assign phase = out_slot_q[1:0];
  assign frame_start = fs_q;
  assign frame_done = fd_q;
  assign tap_hit = hit_q;
  assign busy = (state_q != IDLE);
  assign overrun = ov_q;
endmodule

// File: tb/tb_neuron_slot_sched.sv
// tb_neuron_slot_sched: table-driven and scoreboard checks of neuron_slot_sched at NN=1 and NN=8
module tb_neuron_slot_sched;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [31:0] hc = 0, fl = 16;
  logic [8:0] tp0 = 0, tp1 = 0, tp2 = 0;
  logic [2:0] ten = 3'b000;
  logic t1, v1, fs1, fd1, b1, ov1;
  logic [1:0] idx1, ph1;
  logic [2:0] th1;
  logic t8, v8, fs8, fd8, b8, ov8;
  logic [8:0] idx8;
  logic [1:0] ph8;
  logic [2:0] th8;
  always #5 clk = ~clk;
  neuron_slot_sched #(.NN(1), .CW(32)) u1 (
    .rawclk(clk), .reset(rst), .enable(en), .half_cnt(hc), .frame_len(fl),
    .tap0(tp0[1:0]), .tap1(tp1[1:0]), .tap2(tp2[1:0]), .tap_en(ten), .clr_overrun(clr),
    .tick(t1), .slot_valid(v1), .neuron_index(idx1), .phase(ph1), .frame_start(fs1),
    .frame_done(fd1), .tap_hit(th1), .busy(b1), .overrun(ov1));
  neuron_slot_sched #(.NN(8), .CW(32)) u8 (
    .rawclk(clk), .reset(rst), .enable(en), .half_cnt(hc), .frame_len(fl),
    .tap0(tp0), .tap1(tp1), .tap2(tp2), .tap_en(ten), .clr_overrun(clr),
    .tick(t8), .slot_valid(v8), .neuron_index(idx8), .phase(ph8), .frame_start(fs8),
    .frame_done(fd8), .tap_hit(th8), .busy(b8), .overrun(ov8));
  typedef struct {logic [8:0] idx; logic [1:0] ph; logic fs; logic fd; logic [2:0] hit;} exp_t;
  typedef struct {int hc; int fl; int per; int tk; int vc; int ov;} vec_t;
  exp_t sq[$], tq[$];
  vec_t tbl[6];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, lfs = 0, per1 = 0, vc = 0, tk = 0, rvc = 0, rtk = 0, nfs = 0, thc = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic cond(input int s);
    case (s)
      0: return fs1;
      1: return fd1;
      2: return fd8;
      3: return v1 && idx1 == 2'd1 && ph1 == 2'd3;
      4: return v1 && idx1 == 2'd2 && ph1 == 2'd1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic wait_for(input int s, input int lim, input string nm);
    int n = 0;
    @(negedge clk);
    while (!cond(s) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, cond(s), 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (v1 && sq.size() > 0) begin
      e = sq.pop_front();
      chk("slot_u1", {idx1, ph1, fs1, fd1}, {e.idx[1:0], e.ph, e.fs, e.fd});
    end
    if (th8 != 3'b000 && tq.size() > 0) begin
      e = tq.pop_front();
      chk("tap_u8", {idx8, ph8, th8}, {e.idx, e.ph, e.hit});
    end
    if (fs8) thc = int'(th8 != 3'b000);
    else thc += int'(th8 != 3'b000);
    if (fs1) begin
      per1 = cyc - lfs;
      lfs = cyc;
      rvc = vc;
      rtk = tk;
      vc = int'(v1);
      tk = int'(t1);
      nfs++;
    end else begin
      vc += int'(v1);
      tk += int'(t1);
    end
  end
  initial begin
    int n, cnt;
    tbl = '{'{0, 16, 16, 16, 16, 0}, '{2, 20, 60, 20, 16, 0}, '{0, 5, 16, 16, 16, 1},
            '{1, 16, 32, 16, 16, 0}, '{0, 17, 17, 17, 16, 0}, '{3, 0, 64, 16, 16, 1}};
    repeat (2) @(negedge clk);
    chk("reset_u1", {t1, v1, idx1, ph1, fs1, fd1, th1, b1, ov1}, 0);
    chk("reset_u8", {t8, v8, idx8, ph8, fs8, fd8, th8, b8, ov8}, 0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      hc = tbl[i].hc;
      fl = tbl[i].fl;
      nfs = 0;
      rst = 1'b0;
      en = 1'b1;
      n = 0;
      while (nfs < 3 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("vec%0d_frames", i), nfs >= 3, 1);
      chk($sformatf("vec%0d_period", i), per1, tbl[i].per);
      chk($sformatf("vec%0d_ticks", i), rtk, tbl[i].tk);
      chk($sformatf("vec%0d_slots", i), rvc, tbl[i].vc);
      chk($sformatf("vec%0d_overrun", i), ov1, tbl[i].ov);
    end
    do_reset();
    hc = 0;
    fl = 16;
    for (int k = 0; k < 32; k++)
      sq.push_back('{9'((k % 16) / 4), 2'(k % 4), (k % 16) == 0, (k % 16) == 15, 3'b000});
    rst = 1'b0;
    en = 1'b1;
    n = 0;
    while (sq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_drain", sq.size(), 0);
    chk("sweep_busy_ov", {b1, ov1}, 2'b10);
    do_reset();
    fl = 5;
    rst = 1'b0;
    en = 1'b1;
    wait_for(0, 100, "ov_fs_a");
    repeat (3) @(negedge clk);
    chk("ov_set", ov1, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ov_clr", ov1, 0);
    wait_for(0, 100, "ov_fs_b");
    chk("ov_reset", ov1, 1);
    do_reset();
    hc = 1;
    fl = 16;
    rst = 1'b0;
    en = 1'b1;
    wait_for(3, 100, "drop_slot7");
    en = 1'b0;
    cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      cnt += int'(v1);
      n++;
    end while (!fd1 && n < 100);
    chk("drop_fd", fd1, 1);
    chk("drop_slots", cnt, 8);
    @(negedge clk);
    chk("drop_busy", b1, 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(t1);
    end
    chk("drop_noticks", cnt, 0);
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs1 && n < 50);
    chk("reen_latency", n, 2);
    do_reset();
    hc = 0;
    rst = 1'b0;
    en = 1'b1;
    wait_for(4, 100, "rst_slot9");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", {t1, v1, idx1, ph1, fs1, fd1, th1, b1, ov1}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_restart", {v1, fs1, idx1, ph1, fd1}, 7'b1100000);
    do_reset();
    fl = 0;
    tp0 = 9'd0;
    tp1 = 9'd85;
    tp2 = 9'd170;
    ten = 3'b111;
    tq.push_back('{9'd0, 2'd0, 1'b0, 1'b0, 3'b001});
    tq.push_back('{9'd85, 2'd0, 1'b0, 1'b0, 3'b010});
    tq.push_back('{9'd170, 2'd0, 1'b0, 1'b0, 3'b100});
    rst = 1'b0;
    en = 1'b1;
    wait_for(2, 2200, "tap_fd1");
    chk("tap_cnt1", thc, 3);
    chk("tap_q1", tq.size(), 0);
    ten = 3'b010;
    tq.push_back('{9'd85, 2'd0, 1'b0, 1'b0, 3'b010});
    wait_for(2, 2200, "tap_fd2");
    chk("tap_cnt2", thc, 1);
    chk("tap_q2", tq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
